// File: rtl/sargantana_icache_pkg.sv
// Shared types and derived sizes for the icache IFILL responder.
package sargantana_icache_pkg;

  // Default geometry of one line fill
  localparam int IFILL_PADDR_W = 40;
  localparam int IFILL_LINE_W  = 512;
  localparam int IFILL_BEAT_W  = 128;
  localparam int IFILL_NBEATS  = IFILL_LINE_W / IFILL_BEAT_W;
  localparam int IFILL_BIDX_W  = $clog2(IFILL_NBEATS);

  // Responder FSM states
  typedef enum logic [1:0] {
    IFILL_IDLE  = 2'd0,
    IFILL_REQ   = 2'd1,
    IFILL_DATA  = 2'd2,
    IFILL_DRAIN = 2'd3
  } ifill_state_t;

endpackage

// File: rtl/sargantana_ifill_linebuf.sv
// Line buffer: NBEATS registers of BEAT_W bits, one written per enabled cycle.
module sargantana_ifill_linebuf #(
  parameter int NBEATS = 4,
  parameter int BEAT_W = 128,
  parameter int BIDX_W = 2
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       we_i,
  input  logic [BIDX_W-1:0]          idx_i,
  input  logic [BEAT_W-1:0]          data_i,
  output logic [NBEATS*BEAT_W-1:0]   line_o
);

  logic [NBEATS-1:0][BEAT_W-1:0] buf_q;
  logic [NBEATS-1:0][BEAT_W-1:0] buf_d;

  // Overwrite the addressed slice only; other slices keep older contents
  always_comb begin
    buf_d = buf_q;
    if (we_i) buf_d[idx_i] = data_i;
  end

  // Buffer storage, cleared by reset
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) buf_q <= '0;
    else         buf_q <= buf_d;
  end

  // Beat 0 occupies the least significant slice
  assign line_o = buf_q;

endmodule

// File: rtl/sargantana_icache_ifill_responder.sv
// IFILL responder: one memory read per line fill, beats collected into a
// line buffer, per-beat strobes and a final last/err pulse to the icache.
//
// Handshakes: a request transfers on a cycle where mem_req_valid_o and
// mem_req_ready_i are both high; a beat transfers on a cycle where
// mem_resp_valid_i and mem_resp_ready_o are both high. Valid never drops
// before its transfer, and nothing transfers without both sides high.
module sargantana_icache_ifill_responder
  import sargantana_icache_pkg::*;
#(
  parameter int PADDR_W = IFILL_PADDR_W,
  parameter int LINE_W  = IFILL_LINE_W,
  parameter int BEAT_W  = IFILL_BEAT_W
) (
  input  logic                              clk_i,
  input  logic                              rstn_i,
  input  logic                              ifill_req_valid_i,
  input  logic [PADDR_W-1:0]                ifill_req_paddr_i,
  input  logic                              ifill_kill_i,
  output logic                              ifill_sent_ack_o,
  output logic                              ifill_resp_valid_o,
  output logic [$clog2(LINE_W/BEAT_W)-1:0]  ifill_resp_beat_o,
  output logic                              ifill_resp_last_o,
  output logic                              ifill_resp_err_o,
  output logic [LINE_W-1:0]                 ifill_resp_line_o,
  output logic                              mem_req_valid_o,
  input  logic                              mem_req_ready_i,
  output logic [PADDR_W-1:0]                mem_req_addr_o,
  input  logic                              mem_resp_valid_i,
  input  logic [BEAT_W-1:0]                 mem_resp_data_i,
  input  logic                              mem_resp_err_i,
  output logic                              mem_resp_ready_o,
  output logic [1:0]                        dbg_state_o
);

  localparam int NB     = LINE_W / BEAT_W;
  localparam int BIDX_W = $clog2(NB);
  localparam int OFF    = $clog2(LINE_W / 8);
  localparam logic [PADDR_W-1:0] LINE_MASK = {{(PADDR_W-OFF){1'b1}}, {OFF{1'b0}}};

  ifill_state_t        state_q, state_d;
  logic [PADDR_W-1:0]  addr_q, addr_d;
  logic [BIDX_W-1:0]   cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                killed_q, killed_d;
  logic                rv_q, rv_d;
  logic [BIDX_W-1:0]   rb_q, rb_d;
  logic                rl_q, rl_d;
  logic                re_q, re_d;
  logic                buf_we;
  logic                beat_fire;
  logic                beat_last;

  assign beat_fire = mem_resp_valid_i && (state_q == IFILL_DATA || state_q == IFILL_DRAIN);
  assign beat_last = (cnt_q == BIDX_W'(NB - 1));

  // Next-state, counters, flags and response pulses
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    killed_d = killed_q;
    rv_d     = 1'b0;
    rb_d     = '0;
    rl_d     = 1'b0;
    re_d     = 1'b0;
    buf_we   = 1'b0;
    case (state_q)
      IFILL_IDLE: begin
        if (ifill_req_valid_i) begin
          addr_d   = ifill_req_paddr_i & LINE_MASK;
          cnt_d    = '0;
          err_d    = 1'b0;
          killed_d = 1'b0;
          state_d  = IFILL_REQ;
        end
      end
      IFILL_REQ: begin
        // A kill here cannot retract the request; it only redirects the beats
        if (ifill_kill_i) killed_d = 1'b1;
        if (mem_req_ready_i)
          state_d = (killed_q || ifill_kill_i) ? IFILL_DRAIN : IFILL_DATA;
      end
      IFILL_DATA: begin
        if (beat_fire) begin
          cnt_d = cnt_q + BIDX_W'(1);
          if (ifill_kill_i) begin
            // Beat accepted in the kill cycle is already suppressed
            state_d = beat_last ? IFILL_IDLE : IFILL_DRAIN;
          end else begin
            buf_we = 1'b1;
            err_d  = err_q | mem_resp_err_i;
            rv_d   = 1'b1;
            rb_d   = cnt_q;
            if (beat_last) begin
              rl_d    = 1'b1;
              re_d    = err_q | mem_resp_err_i;
              state_d = IFILL_IDLE;
            end
          end
        end else if (ifill_kill_i) begin
          state_d = IFILL_DRAIN;
        end
      end
      IFILL_DRAIN: begin
        if (beat_fire) begin
          cnt_d = cnt_q + BIDX_W'(1);
          if (beat_last) state_d = IFILL_IDLE;
        end
      end
      default: state_d = IFILL_IDLE;
    endcase
  end

  // State and registered response flops
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IFILL_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      killed_q <= 1'b0;
      rv_q     <= 1'b0;
      rb_q     <= '0;
      rl_q     <= 1'b0;
      re_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      killed_q <= killed_d;
      rv_q     <= rv_d;
      rb_q     <= rb_d;
      rl_q     <= rl_d;
      re_q     <= re_d;
    end
  end

  sargantana_ifill_linebuf #(
    .NBEATS (NB),
    .BEAT_W (BEAT_W),
    .BIDX_W (BIDX_W)
  ) u_linebuf (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .we_i   (buf_we),
    .idx_i  (cnt_q),
    .data_i (mem_resp_data_i),
    .line_o (ifill_resp_line_o)
  );

  assign ifill_sent_ack_o   = (state_q != IFILL_IDLE);
  assign mem_req_valid_o    = (state_q == IFILL_REQ);
  assign mem_req_addr_o     = (state_q == IFILL_REQ) ? addr_q : '0;
  assign mem_resp_ready_o   = (state_q == IFILL_DATA) || (state_q == IFILL_DRAIN);
  assign ifill_resp_valid_o = rv_q;
  assign ifill_resp_beat_o  = rb_q;
  assign ifill_resp_last_o  = rl_q;
  assign ifill_resp_err_o   = re_q;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_sargantana_icache_ifill_responder.sv
// Table-driven bench for the IFILL responder (default 512-bit line, 4 beats).
module tb_sargantana_icache_ifill_responder;

  logic          clk = 1'b0;
  logic          rstn_i;
  logic          ifill_req_valid_i;
  logic [39:0]   ifill_req_paddr_i;
  logic          ifill_kill_i;
  logic          ifill_sent_ack_o;
  logic          ifill_resp_valid_o;
  logic [1:0]    ifill_resp_beat_o;
  logic          ifill_resp_last_o;
  logic          ifill_resp_err_o;
  logic [511:0]  ifill_resp_line_o;
  logic          mem_req_valid_o;
  logic          mem_req_ready_i;
  logic [39:0]   mem_req_addr_o;
  logic          mem_resp_valid_i;
  logic [127:0]  mem_resp_data_i;
  logic          mem_resp_err_i;
  logic          mem_resp_ready_o;
  logic [1:0]    dbg_state_o;

  sargantana_icache_ifill_responder dut (
    .clk_i              (clk),
    .rstn_i             (rstn_i),
    .ifill_req_valid_i  (ifill_req_valid_i),
    .ifill_req_paddr_i  (ifill_req_paddr_i),
    .ifill_kill_i       (ifill_kill_i),
    .ifill_sent_ack_o   (ifill_sent_ack_o),
    .ifill_resp_valid_o (ifill_resp_valid_o),
    .ifill_resp_beat_o  (ifill_resp_beat_o),
    .ifill_resp_last_o  (ifill_resp_last_o),
    .ifill_resp_err_o   (ifill_resp_err_o),
    .ifill_resp_line_o  (ifill_resp_line_o),
    .mem_req_valid_o    (mem_req_valid_o),
    .mem_req_ready_i    (mem_req_ready_i),
    .mem_req_addr_o     (mem_req_addr_o),
    .mem_resp_valid_i   (mem_resp_valid_i),
    .mem_resp_data_i    (mem_resp_data_i),
    .mem_resp_err_i     (mem_resp_err_i),
    .mem_resp_ready_o   (mem_resp_ready_o),
    .dbg_state_o        (dbg_state_o)
  );

  // Clock
  always #5 clk = ~clk;

  // One row = one clock cycle: inputs driven during the cycle and the
  // outputs expected to be visible during that same cycle.
  typedef struct {
    logic         req;
    logic [39:0]  paddr;
    logic         kill;
    logic         rdy;
    logic         bv;
    logic [127:0] d;
    logic         err;
    logic         wr;     // this beat must land in the line buffer
    int           idx;    // slice written when wr
    logic         e_ack, e_mv, e_rr, e_rv;
    logic [1:0]   e_beat;
    logic         e_last, e_err;
    logic [39:0]  e_addr;
  } vec_t;

  vec_t         tbl[$];
  vec_t         cur;
  logic [511:0] line_model;
  int           n_vec = 0;
  int           n_err = 0;
  int           row   = 0;

  function automatic logic [127:0] dat(int f, int b);
    logic [31:0] w;
    w = 32'hA500_0000 + 32'(f * 16 + b);
    return {4{w}};
  endfunction

  task automatic add(input logic req, input logic [39:0] paddr, input logic kill,
                     input logic rdy, input logic bv, input logic [127:0] d,
                     input logic err, input logic wr, input int idx,
                     input logic e_ack, input logic e_mv, input logic e_rr,
                     input logic e_rv, input logic [1:0] e_beat,
                     input logic e_last, input logic e_err, input logic [39:0] e_addr);
    vec_t v;
    v.req = req; v.paddr = paddr; v.kill = kill; v.rdy = rdy; v.bv = bv;
    v.d = d; v.err = err; v.wr = wr; v.idx = idx;
    v.e_ack = e_ack; v.e_mv = e_mv; v.e_rr = e_rr; v.e_rv = e_rv;
    v.e_beat = e_beat; v.e_last = e_last; v.e_err = e_err; v.e_addr = e_addr;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL row %0d %s: got %0h want %0h", row, nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    ifill_req_valid_i = v.req;
    ifill_req_paddr_i = v.paddr;
    ifill_kill_i      = v.kill;
    mem_req_ready_i   = v.rdy;
    mem_resp_valid_i  = v.bv;
    mem_resp_data_i   = v.d;
    mem_resp_err_i    = v.err;
  endtask

  initial begin
    // Reset and idle inputs
    rstn_i = 1'b0;
    ifill_req_valid_i = 1'b0; ifill_req_paddr_i = '0; ifill_kill_i = 1'b0;
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_resp_data_i = '0;
    mem_resp_err_i = 1'b0;
    line_model = '0;
    #1;
    n_vec++;
    chk("reset_outputs",
        {ifill_sent_ack_o, ifill_resp_valid_o, ifill_resp_beat_o, ifill_resp_last_o,
         ifill_resp_err_o, mem_req_valid_o, mem_resp_ready_o}, '0);
    chk("reset_addr", mem_req_addr_o, '0);
    chk("reset_line", ifill_resp_line_o, '0);
    repeat (2) @(posedge clk);
    #1;
    rstn_i = 1'b1;

    // Fill 1: basic fill, consecutive beats
    add(1, 40'h80001234, 0,0,0, '0,0,0,0,  0,0,0,0,0,0,0, '0);
    add(0, '0,           0,1,0, '0,0,0,0,  1,1,0,0,0,0,0, 40'h80001200);
    for (int b = 0; b < 4; b++)
      add(0, '0, 0,0,1, dat(1,b),0,1,b, 1,0,1,(b>0),2'(b>0 ? b-1 : 0),0,0, '0);
    add(0, '0, 0,0,0, '0,0,0,0,  0,0,0,1,2'd3,1,0, '0);

    // Fill 2: request backpressure, a bubble, error on beat 2
    add(1, 40'h12_3456_7FFF, 0,0,0, '0,0,0,0, 0,0,0,0,0,0,0, '0);
    for (int k = 0; k < 5; k++)
      add(0, '0, 0,0,1, dat(9,k),0,0,0, 1,1,0,0,0,0,0, 40'h12_3456_7FC0);
    add(0, '0, 0,1,0, '0,0,0,0,       1,1,0,0,0,0,0, 40'h12_3456_7FC0);
    add(0, '0, 0,0,1, dat(2,0),0,1,0, 1,0,1,0,0,0,0, '0);
    add(0, '0, 0,0,0, '0,0,0,0,       1,0,1,1,2'd0,0,0, '0);
    add(0, '0, 0,0,1, dat(2,1),0,1,1, 1,0,1,0,0,0,0, '0);
    add(0, '0, 0,0,1, dat(2,2),1,1,2, 1,0,1,1,2'd1,0,0, '0);
    add(0, '0, 0,0,1, dat(2,3),0,1,3, 1,0,1,1,2'd2,0,0, '0);
    add(0, '0, 0,0,0, '0,0,0,0,       0,0,0,1,2'd3,1,1, '0);

    // Fill 3: kill after beat 1, beats 2..3 drained silently
    add(1, 40'h4000, 0,0,0, '0,0,0,0,     0,0,0,0,0,0,0, '0);
    add(0, '0, 0,1,0, '0,0,0,0,           1,1,0,0,0,0,0, 40'h4000);
    add(0, '0, 0,0,1, dat(3,0),0,1,0,     1,0,1,0,0,0,0, '0);
    add(0, '0, 0,0,1, dat(3,1),0,1,1,     1,0,1,1,2'd0,0,0, '0);
    add(0, '0, 1,0,0, '0,0,0,0,           1,0,1,1,2'd1,0,0, '0);
    add(0, '0, 0,0,1, dat(3,2),0,0,0,     1,0,1,0,0,0,0, '0);
    add(0, '0, 0,0,1, dat(3,3),0,0,0,     1,0,1,0,0,0,0, '0);
    add(0, '0, 0,0,0, '0,0,0,0,           0,0,0,0,0,0,0, '0);

    // Fill 4: kill in REQ before ready, request still handshakes
    add(1, 40'h0000_0100, 0,0,0, '0,0,0,0, 0,0,0,0,0,0,0, '0);
    add(0, '0, 1,0,0, '0,0,0,0,            1,1,0,0,0,0,0, 40'h100);
    add(0, '0, 0,0,0, '0,0,0,0,            1,1,0,0,0,0,0, 40'h100);
    add(0, '0, 0,1,0, '0,0,0,0,            1,1,0,0,0,0,0, 40'h100);
    for (int b = 0; b < 4; b++)
      add(0, '0, 0,0,1, dat(4,b),0,0,0,    1,0,1,0,0,0,0, '0);
    add(0, '0, 0,0,0, '0,0,0,0,            0,0,0,0,0,0,0, '0);

    // Fill 5: kill coincident with final beat, new request next cycle
    add(1, 40'h2_0000_0040, 0,0,0, '0,0,0,0, 0,0,0,0,0,0,0, '0);
    add(0, '0, 0,1,0, '0,0,0,0,           1,1,0,0,0,0,0, 40'h2_0000_0040);
    add(0, '0, 0,0,1, dat(5,0),0,1,0,     1,0,1,0,0,0,0, '0);
    add(0, '0, 0,0,1, dat(5,1),0,1,1,     1,0,1,1,2'd0,0,0, '0);
    add(0, '0, 0,0,1, dat(5,2),0,1,2,     1,0,1,1,2'd1,0,0, '0);
    add(0, '0, 1,0,1, dat(5,3),0,0,0,     1,0,1,1,2'd2,0,0, '0);
    // Fill 6: accepted in the cycle after the drop, completes cleanly (err 0)
    add(1, 40'h3000, 0,0,0, '0,0,0,0,     0,0,0,0,0,0,0, '0);
    add(0, '0, 0,1,0, '0,0,0,0,           1,1,0,0,0,0,0, 40'h3000);
    for (int b = 0; b < 4; b++)
      add(0, '0, 0,0,1, dat(6,b),0,1,b,   1,0,1,(b>0),2'(b>0 ? b-1 : 0),0,0, '0);
    add(0, '0, 0,0,0, '0,0,0,0,           0,0,0,1,2'd3,1,0, '0);

    // Apply the table
    for (int i = 0; i < tbl.size(); i++) begin
      row = i;
      cur = tbl[i];
      drive(cur);
      #1;
      n_vec++;
      chk("ack",       {511'b0, ifill_sent_ack_o},   {511'b0, cur.e_ack});
      chk("mem_req_v", {511'b0, mem_req_valid_o},    {511'b0, cur.e_mv});
      chk("mem_rsp_r", {511'b0, mem_resp_ready_o},   {511'b0, cur.e_rr});
      chk("resp_v",    {511'b0, ifill_resp_valid_o}, {511'b0, cur.e_rv});
      chk("resp_beat", {510'b0, ifill_resp_beat_o},  {510'b0, cur.e_beat});
      chk("resp_last", {511'b0, ifill_resp_last_o},  {511'b0, cur.e_last});
      chk("resp_err",  {511'b0, ifill_resp_err_o},   {511'b0, cur.e_err});
      if (cur.e_mv) chk("mem_addr", {472'b0, mem_req_addr_o}, {472'b0, cur.e_addr});
      chk("line", ifill_resp_line_o, line_model);
      @(posedge clk);
      if (cur.wr) line_model[cur.idx*128 +: 128] = cur.d;
      #1;
    end

    // Reset in the middle of a fill: everything returns to zero at once
    row = -1;
    ifill_req_valid_i = 1'b1; ifill_req_paddr_i = 40'h7777; ifill_kill_i = 1'b0;
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_resp_err_i = 1'b0;
    step();
    ifill_req_valid_i = 1'b0; mem_req_ready_i = 1'b1;
    step();
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b1; mem_resp_data_i = dat(7,0);
    step();
    mem_resp_valid_i = 1'b0;
    n_vec++;
    chk("pre_reset_resp_v", {511'b0, ifill_resp_valid_o}, {511'b0, 1'b1});
    #2;
    rstn_i = 1'b0;
    #1;
    n_vec++;
    chk("midrst_outputs",
        {ifill_sent_ack_o, ifill_resp_valid_o, ifill_resp_beat_o, ifill_resp_last_o,
         ifill_resp_err_o, mem_req_valid_o, mem_resp_ready_o}, '0);
    chk("midrst_line", ifill_resp_line_o, '0);
    rstn_i = 1'b1;
    step();
    n_vec++;
    chk("post_reset_idle", {511'b0, ifill_sent_ack_o}, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
